// File: rtl/melody_sequencer.sv
// Melody sequencer: steps a 64-entry ROM index at a fixed tempo and renders each
// divider value as a square wave. Define MELODY_GAP_EN to mute the tail of every step.
module melody_sequencer #(
   parameter int unsigned BW          = 16,
   parameter int unsigned STEP_W      = 24,
   parameter int unsigned STEP_CYCLES = 3_000_000,
   parameter int unsigned GAP_CYCLES  = 300_000,
   parameter int unsigned LAST_INDEX  = 63
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          play_i,
   input  logic          stop_i,
   input  logic          loop_i,
   input  logic [BW-1:0] divider_value_i,
   output logic [5:0]    note_index_o,
   output logic          tone_o,
   output logic          busy_o,
   output logic          done_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PLAY,
      ST_DONE
   } state_e;

`ifdef MELODY_GAP_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif

   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
   localparam logic [STEP_W-1:0] GAP_PRE   = STEP_W'(STEP_CYCLES - GAP_CYCLES - 1);
   localparam logic [5:0]        LAST_IDX  = 6'(LAST_INDEX);

   state_e            state_q, state_d;
   logic [5:0]        idx_q, idx_d;
   logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
   logic [BW-1:0]     tone_cnt_q, tone_cnt_d;
   logic              tone_q, tone_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic step_end;
   logic gap_next;

   assign step_end = (step_cnt_q == STEP_LAST);
   // Mute is decided one cycle early so the registered tone is already low
   // on the first cycle of the gap window.
   assign gap_next = GAP_EN && (step_cnt_q >= GAP_PRE);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      step_cnt_d = step_cnt_q;
      tone_cnt_d = '0;
      tone_d     = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (play_i) begin
               state_d    = ST_PLAY;
               idx_d      = '0;
               step_cnt_d = '0;
               busy_d     = 1'b1;
            end
         end
         ST_PLAY: begin
            busy_d = 1'b1;
            if (step_end) begin
               step_cnt_d = '0;
               if (idx_q < LAST_IDX) begin
                  idx_d = idx_q + 6'd1;
               end else if (loop_i) begin
                  idx_d = '0;
               end else begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end else begin
               step_cnt_d = step_cnt_q + STEP_W'(1);
               if (!gap_next && (divider_value_i != '0)) begin
                  if (tone_cnt_q >= divider_value_i - BW'(1)) begin
                     tone_cnt_d = '0;
                     tone_d     = ~tone_q;
                  end else begin
                     tone_cnt_d = tone_cnt_q + BW'(1);
                     tone_d     = tone_q;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase

      if (stop_i) begin
         state_d    = ST_IDLE;
         idx_d      = '0;
         step_cnt_d = '0;
         tone_cnt_d = '0;
         tone_d     = 1'b0;
         busy_d     = 1'b0;
         done_d     = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         step_cnt_q <= '0;
         tone_cnt_q <= '0;
         tone_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         step_cnt_q <= step_cnt_d;
         tone_cnt_q <= tone_cnt_d;
         tone_q     <= tone_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign note_index_o = idx_q;
   assign tone_o       = tone_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a 4-entry stub ROM {2,3,0,1}.
module tb_melody_sequencer;

   localparam int unsigned STEP = 16;
   localparam int unsigned GAP  = 4;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        play_i = 1'b0;
   logic        stop_i = 1'b0;
   logic        loop_i = 1'b0;
   logic [15:0] divider_value_i;
   logic [5:0]  note_index_o;
   logic        tone_o;
   logic        busy_o;
   logic        done_o;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   melody_sequencer #(
      .BW          (16),
      .STEP_W      (24),
      .STEP_CYCLES (STEP),
      .GAP_CYCLES  (GAP),
      .LAST_INDEX  (3)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .play_i          (play_i),
      .stop_i          (stop_i),
      .loop_i          (loop_i),
      .divider_value_i (divider_value_i),
      .note_index_o    (note_index_o),
      .tone_o          (tone_o),
      .busy_o          (busy_o),
      .done_o          (done_o)
   );

   always #5 clk = ~clk;

   function automatic int unsigned rom(input int unsigned idx);
      case (idx)
         0:       rom = 2;
         1:       rom = 3;
         2:       rom = 0;
         3:       rom = 1;
         default: rom = 0;
      endcase
   endfunction

   always_comb divider_value_i = 16'(rom(int'(note_index_o)));

   // Expected tone in cycle j (1..16) of step s: toggles every d clocks from a low start.
   function automatic logic exp_tone(input int unsigned s, input int unsigned j);
      int unsigned d;
      d = rom(s);
      if (d == 0) return 1'b0;
`ifdef MELODY_GAP_EN
      if (j > STEP - GAP) return 1'b0;
`endif
      return 1'(((j - 1) / d) % 2);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, " idx"},  32'(note_index_o), 32'd0);
      check_eq({tag, " tone"}, 32'(tone_o), 32'd0);
      check_eq({tag, " busy"}, 32'(busy_o), 32'd0);
      check_eq({tag, " done"}, 32'(done_o), 32'd0);
   endtask

   task automatic start_play();
      play_i = 1'b1;
      tick();
      play_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check_idle($sformatf("reset_idle c%0d", i));
      end

      // Full non-looping run, every cycle checked.
      loop_i = 1'b0;
      start_play();
      for (int k = 1; k <= 64; k++) begin
         int unsigned s, j;
         s = (k - 1) / STEP;
         j = (k - 1) % STEP + 1;
         check_eq($sformatf("run idx k%0d", k),  32'(note_index_o), 32'(s));
         check_eq($sformatf("run busy k%0d", k), 32'(busy_o), 32'd1);
         check_eq($sformatf("run done k%0d", k), 32'(done_o), 32'd0);
         check_eq($sformatf("run tone k%0d", k), 32'(tone_o), 32'(exp_tone(s, j)));
         tick();
      end
      check_eq("done pulse", 32'(done_o), 32'd1);
      check_eq("done busy",  32'(busy_o), 32'd0);
      check_eq("done idx",   32'(note_index_o), 32'd3);
      check_eq("done tone",  32'(tone_o), 32'd0);
      tick();
      check_idle("after_done");

      // Looping run: wrap 3->0 with no dead cycle.
      loop_i = 1'b1;
      start_play();
      for (int k = 1; k <= 64; k++) begin
         check_eq($sformatf("loop idx k%0d", k), 32'(note_index_o), 32'((k - 1) / STEP));
         tick();
      end
      loop_i = 1'b0;
      check_eq("wrap idx",  32'(note_index_o), 32'd0);
      check_eq("wrap busy", 32'(busy_o), 32'd1);
      check_eq("wrap done", 32'(done_o), 32'd0);
      check_eq("wrap tone j1", 32'(tone_o), 32'(exp_tone(0, 1)));
      tick();
      check_eq("wrap tone j2", 32'(tone_o), 32'(exp_tone(0, 2)));
      tick();
      check_eq("wrap tone j3", 32'(tone_o), 32'(exp_tone(0, 3)));
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      check_idle("stop_after_wrap");

      // Stop in step 1, cycle 5.
      start_play();
      for (int i = 0; i < 20; i++) tick();
      check_eq("pre_stop idx",  32'(note_index_o), 32'd1);
      check_eq("pre_stop tone", 32'(tone_o), 32'(exp_tone(1, 5)));
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      check_idle("stop_step1");
      tick();
      check_idle("stop_step1_next");

      // Stop coinciding with the final step end: no done pulse.
      start_play();
      for (int i = 0; i < 63; i++) tick();
      check_eq("last_cycle idx", 32'(note_index_o), 32'd3);
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      check_idle("stop_at_end");
      tick();
      check_idle("stop_at_end_next");

      // Stop has priority over play in IDLE.
      stop_i = 1'b1;
      play_i = 1'b1;
      tick();
      check_idle("stop_play_idle");
      tick();
      check_idle("stop_play_idle2");
      stop_i = 1'b0;
      play_i = 1'b0;
      tick();
      check_idle("stop_play_release");

      // Reset mid-play.
      start_play();
      for (int i = 0; i < 25; i++) tick();
      check_eq("pre_rst busy", 32'(busy_o), 32'd1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check_idle("rst_mid_play");
      tick();
      check_idle("rst_mid_play_next");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
